// File: rtl/matmul_seq_ctrl.sv
// matmul_seq_ctrl: sequencing controller for the UART-driven matrix multiplier.
// Frames the received byte stream (start byte, size, A elements, B elements),
// writes operands into the A/B memories, starts the multiplier, then streams
// the N x N result back byte by byte (MSB first) through the UART TX handshake.
// Optional feature macro: RX_TIMEOUT_EN (inter-byte receive timeout).
module matmul_seq_ctrl #(
   parameter int         MAX_DIM        = 8,
   parameter int         RES_BYTES      = 2,
   parameter logic [7:0] START_BYTE     = 8'hA5,
   parameter int         TIMEOUT_CYCLES = 1000000,
   localparam int        SW             = $clog2(MAX_DIM + 1),
   localparam int        AW             = (MAX_DIM > 1) ? $clog2(MAX_DIM * MAX_DIM) : 1,
   localparam int        BW             = (RES_BYTES > 1) ? $clog2(RES_BYTES) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          rx_valid,
   input  logic [7:0]    rx_data,
   input  logic          tx_busy,
   input  logic          mult_done,
   output logic          tx_start,
   output logic [AW-1:0] res_rd_addr,
   output logic [BW-1:0] res_byte_sel,
   output logic          mem_wr_en_a,
   output logic          mem_wr_en_b,
   output logic [AW-1:0] mem_wr_addr,
   output logic [7:0]    mem_wr_data,
   output logic          mult_start,
   output logic [SW-1:0] matrix_size,
   output logic [2:0]    state,
   output logic          busy,
   output logic          frame_done,
   output logic          err_size,
   output logic          err_timeout
);

   // Element counter is as wide as N*N so the last-element compare never truncates
   localparam int         CW    = 2 * SW;
   localparam int         TW    = $clog2(MAX_DIM * MAX_DIM * RES_BYTES + 1);
   localparam logic [8:0] MAX_B = 9'(MAX_DIM);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_RX_SIZE = 3'd1;
   localparam logic [2:0] S_RX_A    = 3'd2;
   localparam logic [2:0] S_RX_B    = 3'd3;
   localparam logic [2:0] S_COMPUTE = 3'd4;
   localparam logic [2:0] S_TX_SEND = 3'd5;
   localparam logic [2:0] S_TX_WAIT = 3'd6;

   logic [2:0]    state_q, state_d;
   logic [SW-1:0] size_q, size_d;
   logic [CW-1:0] elem_q, elem_d;
   logic [TW-1:0] txcnt_q, txcnt_d;
   logic          guard_q, guard_d;
   logic          err_size_q, err_size_d;
   logic          busy_q;
   logic          wr_a_q, wr_a_d;
   logic          wr_b_q, wr_b_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]    wr_data_q, wr_data_d;
   logic          mstart_q, mstart_d;
   logic          txstart_q, txstart_d;
   logic          fdone_q, fdone_d;
   logic [AW-1:0] rd_addr_q, rd_addr_d;
   logic [BW-1:0] bsel_q, bsel_d;

   logic [CW-1:0] nn;
   logic [CW-1:0] nn_m1;
   logic [TW-1:0] tx_last;
   logic [TW-1:0] txcnt_inc;
   logic          start_ok;
   logic          size_ok;
   logic          to_expire;

   assign nn        = {{SW{1'b0}}, size_q} * {{SW{1'b0}}, size_q};
   assign nn_m1     = nn - CW'(1);
   assign tx_last   = TW'(nn) * TW'(RES_BYTES) - TW'(1);
   assign txcnt_inc = txcnt_q + TW'(1);
   assign start_ok  = rx_valid && (rx_data == START_BYTE);
   assign size_ok   = (rx_data != 8'd0) && ({1'b0, rx_data} <= MAX_B);

   // Next-state and next-output decode for the framing / compute / transmit sequence
   always_comb begin
      state_d    = state_q;
      size_d     = size_q;
      elem_d     = elem_q;
      txcnt_d    = txcnt_q;
      guard_d    = 1'b0;
      err_size_d = err_size_q;
      wr_a_d     = 1'b0;
      wr_b_d     = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      mstart_d   = 1'b0;
      txstart_d  = 1'b0;
      fdone_d    = 1'b0;
      rd_addr_d  = rd_addr_q;
      bsel_d     = bsel_q;
      case (state_q)
         S_IDLE: begin
            if (start_ok) begin
               state_d    = S_RX_SIZE;
               err_size_d = 1'b0;
            end
         end
         S_RX_SIZE: begin
            if (rx_valid) begin
               if (size_ok) begin
                  size_d  = SW'(rx_data);
                  elem_d  = '0;
                  state_d = S_RX_A;
               end else begin
                  err_size_d = 1'b1;
                  state_d    = S_IDLE;
               end
            end
         end
         S_RX_A, S_RX_B: begin
            if (rx_valid) begin
               wr_a_d    = (state_q == S_RX_A);
               wr_b_d    = (state_q == S_RX_B);
               wr_addr_d = AW'(elem_q);
               wr_data_d = rx_data;
               if (elem_q == nn_m1) begin
                  elem_d = '0;
                  if (state_q == S_RX_A) begin
                     state_d = S_RX_B;
                  end else begin
                     state_d  = S_COMPUTE;
                     mstart_d = 1'b1;
                  end
               end else begin
                  elem_d = elem_q + CW'(1);
               end
            end
         end
         S_COMPUTE: begin
            if (mult_done) begin
               state_d   = S_TX_SEND;
               txcnt_d   = '0;
               rd_addr_d = '0;
               bsel_d    = '0;
            end
         end
         S_TX_SEND: begin
            if (!tx_busy) begin
               txstart_d = 1'b1;
               guard_d   = 1'b1;
               state_d   = S_TX_WAIT;
            end
         end
         S_TX_WAIT: begin
            // guard_q marks the first cycle, where the UART has not yet raised busy
            if (!guard_q && !tx_busy) begin
               if (txcnt_q == tx_last) begin
                  fdone_d = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  txcnt_d   = txcnt_inc;
                  rd_addr_d = AW'(txcnt_inc / TW'(RES_BYTES));
                  bsel_d    = BW'(txcnt_inc % TW'(RES_BYTES));
                  state_d   = S_TX_SEND;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (to_expire) state_d = S_IDLE;
   end

   // FSM state, counters and sticky size error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         size_q     <= '0;
         elem_q     <= '0;
         txcnt_q    <= '0;
         guard_q    <= 1'b0;
         err_size_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         size_q     <= size_d;
         elem_q     <= elem_d;
         txcnt_q    <= txcnt_d;
         guard_q    <= guard_d;
         err_size_q <= err_size_d;
         busy_q     <= (state_d != S_IDLE);
      end
   end

   // Registered memory, multiplier and transmit interface outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_a_q    <= 1'b0;
         wr_b_q    <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         mstart_q  <= 1'b0;
         txstart_q <= 1'b0;
         fdone_q   <= 1'b0;
         rd_addr_q <= '0;
         bsel_q    <= '0;
      end else begin
         wr_a_q    <= wr_a_d;
         wr_b_q    <= wr_b_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         mstart_q  <= mstart_d;
         txstart_q <= txstart_d;
         fdone_q   <= fdone_d;
         rd_addr_q <= rd_addr_d;
         bsel_q    <= bsel_d;
      end
   end

`ifdef RX_TIMEOUT_EN
   localparam int             TOW     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT_CYCLES - 1);

   logic [TOW-1:0] to_cnt_q;
   logic           err_to_q;
   logic           rx_phase;

   assign rx_phase  = (state_q == S_RX_SIZE) || (state_q == S_RX_A) || (state_q == S_RX_B);
   // A byte arriving on the expiry cycle wins: expiry requires rx_valid low
   assign to_expire = rx_phase && !rx_valid && (to_cnt_q == TO_LAST);

   // Count idle cycles between received bytes; expiry aborts the frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt_q <= '0;
         err_to_q <= 1'b0;
      end else begin
         if (rx_phase && !rx_valid && !to_expire) to_cnt_q <= to_cnt_q + TOW'(1);
         else                                     to_cnt_q <= '0;
         if (state_q == S_IDLE && start_ok) err_to_q <= 1'b0;
         else if (to_expire)                err_to_q <= 1'b1;
      end
   end

   assign err_timeout = err_to_q;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign to_expire          = 1'b0;
   assign err_timeout        = 1'b0;
`endif

   assign state        = state_q;
   assign busy         = busy_q;
   assign matrix_size  = size_q;
   assign err_size     = err_size_q;
   assign mem_wr_en_a  = wr_a_q;
   assign mem_wr_en_b  = wr_b_q;
   assign mem_wr_addr  = wr_addr_q;
   assign mem_wr_data  = wr_data_q;
   assign mult_start   = mstart_q;
   assign tx_start     = txstart_q;
   assign frame_done   = fdone_q;
   assign res_rd_addr  = rd_addr_q;
   assign res_byte_sel = bsel_q;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Directed testbench for matmul_seq_ctrl (MAX_DIM=8, RES_BYTES=2, TIMEOUT_CYCLES=50).
`timescale 1ns/1ps
module tb_matmul_seq_ctrl;

   localparam int AW = 6;
   localparam int BW = 1;
   localparam int SW = 4;

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b0;
   logic          rx_valid  = 1'b0;
   logic [7:0]    rx_data   = 8'd0;
   logic          tx_busy   = 1'b0;
   logic          mult_done = 1'b0;
   logic          tx_start;
   logic [AW-1:0] res_rd_addr;
   logic [BW-1:0] res_byte_sel;
   logic          mem_wr_en_a;
   logic          mem_wr_en_b;
   logic [AW-1:0] mem_wr_addr;
   logic [7:0]    mem_wr_data;
   logic          mult_start;
   logic [SW-1:0] matrix_size;
   logic [2:0]    state;
   logic          busy;
   logic          frame_done;
   logic          err_size;
   logic          err_timeout;

   matmul_seq_ctrl #(
      .MAX_DIM(8), .RES_BYTES(2), .START_BYTE(8'hA5), .TIMEOUT_CYCLES(50)
   ) dut (
      .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
      .tx_busy(tx_busy), .mult_done(mult_done), .tx_start(tx_start),
      .res_rd_addr(res_rd_addr), .res_byte_sel(res_byte_sel),
      .mem_wr_en_a(mem_wr_en_a), .mem_wr_en_b(mem_wr_en_b),
      .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
      .mult_start(mult_start), .matrix_size(matrix_size), .state(state),
      .busy(busy), .frame_done(frame_done), .err_size(err_size),
      .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int busy_len = 0;

   logic [AW-1:0] a_addr[$];
   logic [7:0]    a_data[$];
   logic [AW-1:0] b_addr[$];
   logic [7:0]    b_data[$];
   logic [AW-1:0] tx_addr[$];
   logic [BW-1:0] tx_sel[$];
   int            tx_cyc[$];
   int            n_mstart, n_fdone, n_overlap, n_tx_in_busy, n_unstable;
   logic [AW-1:0] held_addr;
   logic [BW-1:0] held_sel;

   always @(posedge clk) cyc++;

   // Event logger, sampled on the falling edge
   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_wr_en_a) begin a_addr.push_back(mem_wr_addr); a_data.push_back(mem_wr_data); end
         if (mem_wr_en_b) begin b_addr.push_back(mem_wr_addr); b_data.push_back(mem_wr_data); end
         if (mult_start) n_mstart++;
         if (frame_done) n_fdone++;
         if ((mem_wr_en_a && mem_wr_en_b) || (tx_start && (mem_wr_en_a || mem_wr_en_b))) n_overlap++;
         if (tx_start) begin
            if (tx_busy) n_tx_in_busy++;
            tx_addr.push_back(res_rd_addr);
            tx_sel.push_back(res_byte_sel);
            tx_cyc.push_back(cyc);
            held_addr = res_rd_addr;
            held_sel  = res_byte_sel;
         end else if (state == 3'd6 && (res_rd_addr !== held_addr || res_byte_sel !== held_sel)) begin
            n_unstable++;
         end
      end
   end

   // UART TX model: busy for busy_len cycles starting the cycle after tx_start
   always begin
      @(negedge clk);
      if (tx_start === 1'b1 && busy_len > 0) begin
         @(posedge clk);
         #1 tx_busy = 1'b1;
         repeat (busy_len) @(posedge clk);
         #1 tx_busy = 1'b0;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_logs();
      a_addr.delete(); a_data.delete(); b_addr.delete(); b_data.delete();
      tx_addr.delete(); tx_sel.delete(); tx_cyc.delete();
      n_mstart = 0; n_fdone = 0; n_overlap = 0; n_tx_in_busy = 0; n_unstable = 0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk);
      #1 rx_valid = 1'b1; rx_data = b;
      @(posedge clk);
      #1 rx_valid = 1'b0;
   endtask

   task automatic send_operands(input int n);
      for (int i = 0; i < n * n; i++) send_byte(8'(i + 1));
      for (int i = 0; i < n * n; i++) send_byte(8'(8'h80 + i));
   endtask

   task automatic finish_frame(input int n);
      int bound;
      bound = 0;
      while (n_mstart == 0 && bound < 20) begin @(posedge clk); bound++; end
      checks++;
      if (n_mstart == 0) begin
         errors++; $display("FAIL mult_start_wait: got no pulse, want one within 20 cycles");
      end
      repeat (4) @(posedge clk);
      #1 mult_done = 1'b1;
      @(posedge clk);
      #1 mult_done = 1'b0;
      bound = 0;
      while (n_fdone == 0 && bound < n * n * 2 * (busy_len + 8) + 50) begin @(posedge clk); bound++; end
      checks++;
      if (n_fdone == 0) begin
         errors++; $display("FAIL frame_done_wait: got no pulse within %0d cycles", bound);
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic do_frame(input int n);
      send_byte(8'hA5);
      send_byte(8'(n));
      send_operands(n);
      finish_frame(n);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({tx_start, mem_wr_en_a, mem_wr_en_b, mult_start, busy, frame_done, err_size, err_timeout} !== 8'b0) begin
         errors++; $display("FAIL reset_flags: got %b want 00000000",
            {tx_start, mem_wr_en_a, mem_wr_en_b, mult_start, busy, frame_done, err_size, err_timeout});
      end
      checks++;
      if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
      checks++;
      if ({res_rd_addr, res_byte_sel, mem_wr_addr, mem_wr_data, matrix_size} !== 25'd0) begin
         errors++; $display("FAIL reset_buses: got %h want 0",
            {res_rd_addr, res_byte_sel, mem_wr_addr, mem_wr_data, matrix_size});
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (state !== 3'd0 || busy !== 1'b0) begin
         errors++; $display("FAIL reset_release: got state %0d busy %b want 0 0", state, busy);
      end
   endtask

   task automatic test_basic();
      clear_logs();
      busy_len = 0;
      send_byte(8'hA5);
      checks++;
      if (state !== 3'd1 || busy !== 1'b1) begin
         errors++; $display("FAIL basic_start: got state %0d busy %b want 1 1", state, busy);
      end
      send_byte(8'h03);
      checks++;
      if (state !== 3'd2 || matrix_size !== 4'd3) begin
         errors++; $display("FAIL basic_size: got state %0d size %0d want 2 3", state, matrix_size);
      end
      send_byte(8'h01);
      checks++;
      if (mem_wr_en_a !== 1'b1 || mem_wr_addr !== 6'd0 || mem_wr_data !== 8'h01) begin
         errors++; $display("FAIL basic_first_write: got en %b addr %0d data %h want 1 0 01",
            mem_wr_en_a, mem_wr_addr, mem_wr_data);
      end
      for (int i = 1; i < 9; i++) send_byte(8'(i + 1));
      for (int i = 0; i < 9; i++) send_byte(8'(8'h80 + i));
      finish_frame(3);
      checks++;
      if (a_addr.size() != 9 || b_addr.size() != 9) begin
         errors++; $display("FAIL basic_write_count: got A %0d B %0d want 9 9", a_addr.size(), b_addr.size());
      end
      for (int i = 0; i < 9; i++) begin
         if (i < a_addr.size()) begin
            checks++;
            if (a_addr[i] !== 6'(i) || a_data[i] !== 8'(i + 1)) begin
               errors++; $display("FAIL basic_a[%0d]: got addr %0d data %h want %0d %h", i, a_addr[i], a_data[i], i, i + 1);
            end
         end
         if (i < b_addr.size()) begin
            checks++;
            if (b_addr[i] !== 6'(i) || b_data[i] !== 8'(8'h80 + i)) begin
               errors++; $display("FAIL basic_b[%0d]: got addr %0d data %h want %0d %h", i, b_addr[i], b_data[i], i, 8'h80 + i);
            end
         end
      end
      checks++;
      if (n_mstart != 1) begin errors++; $display("FAIL basic_mult_start: got %0d pulse cycles want 1", n_mstart); end
      checks++;
      if (tx_addr.size() != 18) begin errors++; $display("FAIL basic_tx_count: got %0d want 18", tx_addr.size()); end
      for (int i = 0; i < 18; i++) begin
         if (i < tx_addr.size()) begin
            checks++;
            if (tx_addr[i] !== 6'(i / 2) || tx_sel[i] !== 1'(i % 2)) begin
               errors++; $display("FAIL basic_tx[%0d]: got addr %0d sel %0d want %0d %0d", i, tx_addr[i], tx_sel[i], i / 2, i % 2);
            end
            if (i > 0) begin
               checks++;
               if (tx_cyc[i] - tx_cyc[i-1] != 3) begin
                  errors++; $display("FAIL basic_tx_gap[%0d]: got %0d want 3", i, tx_cyc[i] - tx_cyc[i-1]);
               end
            end
         end
      end
      checks++;
      if (n_fdone != 1 || state !== 3'd0 || busy !== 1'b0) begin
         errors++; $display("FAIL basic_end: got fdone %0d state %0d busy %b want 1 0 0", n_fdone, state, busy);
      end
      checks++;
      if (n_overlap != 0) begin errors++; $display("FAIL basic_overlap: got %0d want 0", n_overlap); end
   endtask

   task automatic test_ignore_and_size();
      clear_logs();
      send_byte(8'h00);
      send_byte(8'h17);
      checks++;
      if (state !== 3'd0 || busy !== 1'b0) begin
         errors++; $display("FAIL ignore_idle: got state %0d busy %b want 0 0", state, busy);
      end
      @(posedge clk); #1 mult_done = 1'b1;
      @(posedge clk); #1 mult_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (state !== 3'd0 || tx_addr.size() != 0) begin
         errors++; $display("FAIL ignore_mult_done: got state %0d tx %0d want 0 0", state, tx_addr.size());
      end
      send_byte(8'hA5);
      send_byte(8'h00);
      checks++;
      if (err_size !== 1'b1 || state !== 3'd0 || matrix_size !== 4'd3) begin
         errors++; $display("FAIL size_zero: got err %b state %0d size %0d want 1 0 3", err_size, state, matrix_size);
      end
      send_byte(8'hA5);
      checks++;
      if (err_size !== 1'b0 || state !== 3'd1) begin
         errors++; $display("FAIL size_clear1: got err %b state %0d want 0 1", err_size, state);
      end
      send_byte(8'h09);
      checks++;
      if (err_size !== 1'b1 || state !== 3'd0 || matrix_size !== 4'd3) begin
         errors++; $display("FAIL size_over: got err %b state %0d size %0d want 1 0 3", err_size, state, matrix_size);
      end
      send_byte(8'hA5);
      checks++;
      if (err_size !== 1'b0 || state !== 3'd1) begin
         errors++; $display("FAIL size_clear2: got err %b state %0d want 0 1", err_size, state);
      end
      send_byte(8'hFF);
      checks++;
      if (err_size !== 1'b1 || state !== 3'd0 || a_addr.size() != 0) begin
         errors++; $display("FAIL size_ff: got err %b state %0d writes %0d want 1 0 0", err_size, state, a_addr.size());
      end
   endtask

   task automatic test_tx_busy();
      clear_logs();
      busy_len = 20;
      do_frame(2);
      checks++;
      if (tx_addr.size() != 8) begin errors++; $display("FAIL busy_tx_count: got %0d want 8", tx_addr.size()); end
      for (int i = 0; i < tx_addr.size(); i++) begin
         checks++;
         if (tx_addr[i] !== 6'(i / 2) || tx_sel[i] !== 1'(i % 2)) begin
            errors++; $display("FAIL busy_tx[%0d]: got addr %0d sel %0d want %0d %0d", i, tx_addr[i], tx_sel[i], i / 2, i % 2);
         end
         if (i > 0) begin
            checks++;
            if (tx_cyc[i] - tx_cyc[i-1] < 21) begin
               errors++; $display("FAIL busy_tx_gap[%0d]: got %0d want at least 21", i, tx_cyc[i] - tx_cyc[i-1]);
            end
         end
      end
      checks++;
      if (n_tx_in_busy != 0 || n_unstable != 0) begin
         errors++; $display("FAIL busy_handshake: got start_in_busy %0d unstable %0d want 0 0", n_tx_in_busy, n_unstable);
      end
      checks++;
      if (n_fdone != 1 || n_mstart != 1 || err_size !== 1'b0) begin
         errors++; $display("FAIL busy_end: got fdone %0d mstart %0d err %b want 1 1 0", n_fdone, n_mstart, err_size);
      end
      busy_len = 0;
   endtask

   task automatic test_max_dim();
      clear_logs();
      do_frame(8);
      checks++;
      if (a_addr.size() != 64 || b_addr.size() != 64) begin
         errors++; $display("FAIL max_write_count: got A %0d B %0d want 64 64", a_addr.size(), b_addr.size());
      end
      if (a_addr.size() == 64 && b_addr.size() == 64) begin
         checks++;
         if (a_addr[63] !== 6'd63 || b_addr[63] !== 6'd63 || b_data[63] !== 8'hBF) begin
            errors++; $display("FAIL max_last_write: got A %0d B %0d data %h want 63 63 bf", a_addr[63], b_addr[63], b_data[63]);
         end
      end
      checks++;
      if (tx_addr.size() != 128) begin errors++; $display("FAIL max_tx_count: got %0d want 128", tx_addr.size()); end
      if (tx_addr.size() == 128) begin
         checks++;
         if (tx_addr[127] !== 6'd63 || tx_sel[127] !== 1'b1 || tx_addr[64] !== 6'd32 || tx_sel[64] !== 1'b0) begin
            errors++; $display("FAIL max_tx_addr: got last %0d/%0d mid %0d/%0d want 63/1 32/0",
               tx_addr[127], tx_sel[127], tx_addr[64], tx_sel[64]);
         end
      end
      checks++;
      if (n_fdone != 1 || n_mstart != 1 || state !== 3'd0 || matrix_size !== 4'd8) begin
         errors++; $display("FAIL max_end: got fdone %0d mstart %0d state %0d size %0d want 1 1 0 8",
            n_fdone, n_mstart, state, matrix_size);
      end
   endtask

   task automatic test_reset_mid();
      clear_logs();
      send_byte(8'hA5);
      send_byte(8'h03);
      for (int i = 0; i < 9; i++) send_byte(8'(i + 1));
      for (int i = 0; i < 4; i++) send_byte(8'(8'h80 + i));
      checks++;
      if (state !== 3'd3 || mem_wr_en_b !== 1'b1 || mem_wr_addr !== 6'd3 || mem_wr_data !== 8'h83) begin
         errors++; $display("FAIL mid_before: got state %0d en %b addr %0d data %h want 3 1 3 83",
            state, mem_wr_en_b, mem_wr_addr, mem_wr_data);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (state !== 3'd0 || mem_wr_en_b !== 1'b0 || mem_wr_addr !== 6'd0 || mem_wr_data !== 8'h00 ||
          matrix_size !== 4'd0 || busy !== 1'b0) begin
         errors++; $display("FAIL mid_async_reset: got state %0d en %b addr %0d data %h size %0d busy %b want all 0",
            state, mem_wr_en_b, mem_wr_addr, mem_wr_data, matrix_size, busy);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      clear_logs();
      do_frame(2);
      checks++;
      if (a_addr.size() != 4 || b_addr.size() != 4 || tx_addr.size() != 8 || n_fdone != 1 || n_mstart != 1) begin
         errors++; $display("FAIL mid_recover: got A %0d B %0d tx %0d fdone %0d mstart %0d want 4 4 8 1 1",
            a_addr.size(), b_addr.size(), tx_addr.size(), n_fdone, n_mstart);
      end
   endtask

   task automatic test_timeout();
      clear_logs();
      send_byte(8'hA5);
      send_byte(8'h03);
      send_byte(8'h01);
`ifdef RX_TIMEOUT_EN
      repeat (49) @(posedge clk);
      #1;
      checks++;
      if (state !== 3'd2 || err_timeout !== 1'b0) begin
         errors++; $display("FAIL to_before: got state %0d err %b want 2 0", state, err_timeout);
      end
      @(posedge clk);
      #1;
      checks++;
      if (state !== 3'd0 || err_timeout !== 1'b1) begin
         errors++; $display("FAIL to_expire: got state %0d err %b want 0 1", state, err_timeout);
      end
      send_byte(8'h02);
      checks++;
      if (a_addr.size() != 1 || state !== 3'd0) begin
         errors++; $display("FAIL to_no_write: got writes %0d state %0d want 1 0", a_addr.size(), state);
      end
      send_byte(8'hA5);
      checks++;
      if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_clear: got %b want 0", err_timeout); end
      send_byte(8'h03);
      send_byte(8'h01);
      repeat (48) @(posedge clk);
      send_byte(8'h02);
      checks++;
      if (state !== 3'd2 || err_timeout !== 1'b0 || mem_wr_en_a !== 1'b1 || mem_wr_addr !== 6'd1) begin
         errors++; $display("FAIL to_same_cycle: got state %0d err %b en %b addr %0d want 2 0 1 1",
            state, err_timeout, mem_wr_en_a, mem_wr_addr);
      end
`else
      repeat (80) @(posedge clk);
      #1;
      checks++;
      if (state !== 3'd2 || err_timeout !== 1'b0) begin
         errors++; $display("FAIL no_timeout_wait: got state %0d err %b want 2 0", state, err_timeout);
      end
      send_byte(8'h02);
      checks++;
      if (mem_wr_en_a !== 1'b1 || mem_wr_addr !== 6'd1 || mem_wr_data !== 8'h02) begin
         errors++; $display("FAIL no_timeout_write: got en %b addr %0d data %h want 1 1 02",
            mem_wr_en_a, mem_wr_addr, mem_wr_data);
      end
`endif
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      clear_logs();
      held_addr = '0;
      held_sel  = '0;
      test_reset();
      test_basic();
      test_ignore_and_size();
      test_tx_busy();
      test_max_dim();
      test_reset_mid();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/matmul_seq_ctrl.md
Name: matmul_seq_ctrl

Overview:
Parametrised sequencing controller for the UART-driven matrix multiplier. It performs these steps in order:
- Frames the incoming byte stream: start byte, size byte, then A and B elements.
- Writes the A and B elements into the operand memories with explicit addresses.
- Starts and awaits the multiplier.
- Streams the N×N result back byte by byte through the UART TX handshake.

It replaces the fixed 3×3 controller and adds size validation, result byte sequencing and memory addressing.

Parameters:
- MAX_DIM, 8: largest accepted matrix dimension N.
- RES_BYTES, 2: bytes per result element, sent MSB first.
- START_BYTE, 8'hA5: frame start marker.
- TIMEOUT_CYCLES, 1000000: inter-byte timeout. Used only with RX_TIMEOUT_EN.
- Derived, not overridable:
  - SW = $clog2(MAX_DIM+1)
  - AW = $clog2(MAX_DIM*MAX_DIM)
  - BW = max(1, $clog2(RES_BYTES))

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- rx_valid  in  1  one-cycle pulse, rx_data valid
- rx_data  in  8  received byte
- tx_busy  in  1  UART TX transmitting
- mult_done  in  1  multiplier finished (level or pulse)
- tx_start  out  1  one-cycle pulse, send byte selected by res_rd_addr/res_byte_sel
- res_rd_addr  out  AW  result memory element index
- res_byte_sel  out  BW  byte of result element, 0 = MSB
- mem_wr_en_a  out  1  write strobe, operand A memory
- mem_wr_en_b  out  1  write strobe, operand B memory
- mem_wr_addr  out  AW  operand write address (row-major)
- mem_wr_data  out  8  operand write data
- mult_start  out  1  one-cycle pulse to multiplier
- matrix_size  out  SW  latched N
- state  out  3  current FSM state
- busy  out  1  high in any state except IDLE
- frame_done  out  1  one-cycle pulse after last TX byte completes
- err_size  out  1  sticky; cleared by the next accepted START_BYTE
- err_timeout  out  1  sticky; cleared by the next accepted START_BYTE

Behaviour:
- Reset: all outputs 0, state=IDLE, internal counters 0. Reset takes effect immediately, including mid-frame; no partial output completes.
- All outputs are registered. Write strobes and address/data appear the cycle after the qualifying rx_valid.
- State encoding: IDLE=0, RX_SIZE=1, RX_A=2, RX_B=3, COMPUTE=4, TX_SEND=5, TX_WAIT=6.
- IDLE:
  - rx_valid with rx_data==START_BYTE → RX_SIZE; clear err_size and err_timeout.
  - Any other byte is ignored.
- RX_SIZE, on rx_valid:
  - rx_data in 1..MAX_DIM: latch matrix_size, elem_cnt=0 → RX_A.
  - Otherwise: set err_size → IDLE; matrix_size unchanged.
- RX_A, on each rx_valid:
  - mem_wr_en_a=1, mem_wr_addr=elem_cnt, mem_wr_data=rx_data, elem_cnt++.
  - When elem_cnt==N*N-1: → RX_B, elem_cnt=0.
- RX_B: same as RX_A using mem_wr_en_b.
  - On the last element: → COMPUTE; mult_start pulses exactly one cycle on COMPUTE entry.
- N*N is computed at 2*SW bits. The last-element compare uses the full width; no truncation.
- COMPUTE: mult_done → TX_SEND with byte index tx_cnt=0. mult_done is ignored in every other state.
- TX_SEND:
  - Drive res_rd_addr = tx_cnt / RES_BYTES and res_byte_sel = tx_cnt % RES_BYTES.
  - When tx_busy==0: pulse tx_start → TX_WAIT.
- TX_WAIT:
  - First cycle: tx_busy is ignored (guard cycle).
  - After the guard cycle, wait for tx_busy==0. Then:
    - If tx_cnt == N*N*RES_BYTES-1: pulse frame_done → IDLE.
    - Else tx_cnt++ → TX_SEND.
- Address and byte-select are held stable from tx_start until leaving TX_WAIT.
- rx_valid is ignored in COMPUTE, TX_SEND and TX_WAIT; no memory writes occur there.
- N=1 edge case: one A byte, one B byte, RES_BYTES TX bytes.
- Write strobes are never asserted simultaneously with each other or with tx_start.

Optional Feature:
RX_TIMEOUT_EN.
- Defined:
  - A counter runs in RX_SIZE, RX_A and RX_B and resets on every rx_valid.
  - On reaching TIMEOUT_CYCLES: set err_timeout → IDLE. No further memory writes.
  - If rx_valid arrives on the same cycle as expiry, the byte is accepted and no timeout occurs.
- Undefined: no counter; the FSM waits indefinitely; err_timeout is tied to 0.

Test Plan:
- Frame A5, 03, 9 A bytes 1..9, 9 B bytes; mult_done 5 cycles after mult_start → 9 mem_wr_en_a writes at addr 0..8, then 9 B writes; one mult_start pulse; 18 tx_start pulses with res_rd_addr 0,0,1,1..8,8 and res_byte_sel 0,1 alternating; frame_done once; state=IDLE.
- Bytes 00 then 17 before A5 → ignored, no state change. Then A5, 00 → err_size=1, IDLE. Then A5, 09 (MAX_DIM=8) → err_size=1. Then A5 → err_size cleared.
- tx_busy held high 20 cycles after each tx_start → no second tx_start until busy drops; address stable throughout.
- N=MAX_DIM=8 → 64+64 writes, last mem_wr_addr=63, 128 TX bytes.
- rst_n low in RX_B after 4 bytes → all outputs 0 asynchronously; a new frame completes normally.
- With RX_TIMEOUT_EN and TIMEOUT_CYCLES=50, stall 50 cycles in RX_A → err_timeout=1, IDLE. Stall 49 cycles, then rx_valid → no timeout.
